din_event_arbiter: RTL and testbench

- Round-robin scheduler that shares one downstream resource among NCH asynchronous request lines.
- Each DIN line carries random-width asynchronous pulses. Each line is synchronized and rising-edge detected, then latched as a pending event.
- One requester at a time is granted the resource for HOLD cycles.
- Sits between raw asynchronous inputs (buttons, external strobes) and a single-consumer datapath.

---
 rtl/din_arb_pkg.sv | 17 +
 rtl/din_edge_sync.sv | 28 ++
 rtl/din_event_arbiter.sv | 126 ++++++++++++
 tb/tb_din_event_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/din_arb_pkg.sv
// rtl/din_arb_pkg.sv - shared types, defaults and round-robin helper for the DIN event arbiter
package din_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NCH  = 4;
  localparam int unsigned DEF_HOLD = 3;

  // Channel that follows idx in round-robin order; n-1 wraps back to 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/din_edge_sync.sv
// rtl/din_edge_sync.sv - three-flop synchronizer with rising-edge detect for one async line
module din_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Only flopped stages feed the detector, so din_i never reaches logic directly.
  assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/din_event_arbiter.sv
// rtl/din_event_arbiter.sv - round-robin grant of one shared resource among NCH async event lines
module din_event_arbiter
  import din_arb_pkg::*;
#(
  parameter int unsigned NCH  = DEF_NCH,
  parameter int unsigned HOLD = DEF_HOLD,
  parameter int unsigned IDW  = $clog2(NCH)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NCH-1:0] DIN,
  output logic           DOUT,
  output logic [NCH-1:0] GNT,
  output logic [IDW-1:0] GNT_ID,
  output logic           BUSY,
  output logic [NCH-1:0] PEND,
  output logic [NCH-1:0] OVF
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  arb_state_e     state_q;
  logic           dout_q;
  logic           busy_q;
  logic [NCH-1:0] gnt_q;
  logic [IDW-1:0] gnt_id_q;
  logic [IDW-1:0] last_q;
  logic [CW-1:0]  cnt_q;
  logic [NCH-1:0] pend_q;
  logic [NCH-1:0] pend_d;
  logic [NCH-1:0] ovf_q;
  logic [NCH-1:0] ovf_d;

  logic [NCH-1:0] edge_w;
  logic           win_valid;
  logic [IDW-1:0] win_id;
  logic [NCH-1:0] win_oh;
  logic           grant_now;
  logic [NCH-1:0] clr_mask;
  int unsigned    idx;
  logic [IDW-1:0] idx_l;

  for (genvar g = 0; g < NCH; g++) begin : g_sync
    din_edge_sync u_sync (
      .clk_i  (CLK),
      .rst_ni (RST),
      .din_i  (DIN[g]),
      .edge_o (edge_w[g])
    );
  end

  // Scan starts one past the last winner so every pending channel is reached within NCH grants.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    idx_l     = '0;
    idx       = 32'(last_q);
    for (int i = 0; i < int'(NCH); i++) begin
      idx   = rr_next(idx, NCH);
      idx_l = IDW'(idx);
      if (!win_valid && pend_q[idx_l]) begin
        win_valid = 1'b1;
        win_id    = idx_l;
      end
    end
  end

  assign win_oh    = {{(NCH-1){1'b0}}, 1'b1} << win_id;
  assign grant_now = (state_q == IDLE) && win_valid;
  assign clr_mask  = grant_now ? win_oh : '0;

  // A fresh edge beats the grant clear; an edge landing on a still-pending flag coalesces and is flagged.
  always_comb begin
    pend_d = (pend_q & ~clr_mask) | edge_w;
    ovf_d  = ovf_q | (edge_w & pend_q & ~clr_mask);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      dout_q   <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      last_q   <= IDW'(NCH - 1);
      cnt_q    <= '0;
      pend_q   <= '0;
      ovf_q    <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            gnt_q    <= win_oh;
            gnt_id_q <= win_id;
            dout_q   <= 1'b1;
            busy_q   <= 1'b1;
            last_q   <= win_id;
            cnt_q    <= CW'(HOLD - 1);
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          dout_q <= 1'b0;
          if (cnt_q == '0) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DOUT   = dout_q;
  assign GNT    = gnt_q;
  assign GNT_ID = gnt_id_q;
  assign BUSY   = busy_q;
  assign PEND   = pend_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_din_event_arbiter.sv
// tb/tb_din_event_arbiter.sv - scoreboard bench for din_event_arbiter (NCH=4, HOLD=3)
module tb_din_event_arbiter;

  localparam int NCH  = 4;
  localparam int HOLD = 3;
  localparam int IDW  = 2;

  logic           CLK;
  logic           RST;
  logic [NCH-1:0] DIN;
  logic           DOUT;
  logic [NCH-1:0] GNT;
  logic [IDW-1:0] GNT_ID;
  logic           BUSY;
  logic [NCH-1:0] PEND;
  logic [NCH-1:0] OVF;

  int checks = 0;
  int errors = 0;
  int sb[$];

  din_event_arbiter #(.NCH(NCH), .HOLD(HOLD), .IDW(IDW)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .DIN    (DIN),
    .DOUT   (DOUT),
    .GNT    (GNT),
    .GNT_ID (GNT_ID),
    .BUSY   (BUSY),
    .PEND   (PEND),
    .OVF    (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  // Each completion strobe must match the next expected grant, in order.
  always @(negedge CLK) begin
    if (RST === 1'b1 && DOUT === 1'b1) begin
      int exp_id;
      logic [NCH-1:0] exp_gnt;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_grant GNT_ID=%0d GNT=%b required no grant", GNT_ID, GNT);
      end else begin
        exp_id  = sb.pop_front();
        exp_gnt = 4'b0001 << exp_id;
        if (GNT_ID !== IDW'(exp_id) || GNT !== exp_gnt || BUSY !== 1'b1) begin
          errors++;
          $display("FAIL sb_grant GNT_ID=%0d GNT=%b BUSY=%b required GNT_ID=%0d GNT=%b BUSY=1",
                   GNT_ID, GNT, BUSY, exp_id, exp_gnt);
        end
      end
    end
  end

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    repeat (3) tick();
    while (!(BUSY === 1'b0 && PEND === '0 && DOUT === 1'b0) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s_timeout BUSY=%b PEND=%b required idle within 60 cycles", name, BUSY, PEND);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_left pending=%0d required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      DIN = (i % 2 == 0) ? 4'hF : 4'h0;
      tick();
      checks++;
      if ({DOUT, GNT, GNT_ID, BUSY, PEND, OVF} !== '0) begin
        errors++;
        $display("FAIL reset_outputs DOUT=%b GNT=%b GNT_ID=%0d BUSY=%b PEND=%b OVF=%b required all 0",
                 DOUT, GNT, GNT_ID, BUSY, PEND, OVF);
      end
    end
    DIN = '0;
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (PEND !== '0 || GNT !== '0 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet cycle=%0d PEND=%b GNT=%b BUSY=%b required 0", i, PEND, GNT, BUSY);
      end
    end
  endtask

  task automatic test_single();
    logic [NCH-1:0] e_pend [7] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [NCH-1:0] e_gnt  [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic           e_dout [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic           e_busy [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    DIN = 4'b0100;
    sb.push_back(2);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 1) DIN = '0;
      checks++;
      if (PEND !== e_pend[i] || GNT !== e_gnt[i] || DOUT !== e_dout[i] || BUSY !== e_busy[i] ||
          (e_busy[i] && GNT_ID !== 2'd2)) begin
        errors++;
        $display("FAIL single_c%0d PEND=%b GNT=%b DOUT=%b BUSY=%b ID=%0d required PEND=%b GNT=%b DOUT=%b BUSY=%b ID=2",
                 i + 1, PEND, GNT, DOUT, BUSY, GNT_ID, e_pend[i], e_gnt[i], e_dout[i], e_busy[i]);
      end
    end
    checks++;
    if (GNT_ID !== 2'd2) begin
      errors++;
      $display("FAIL single_id_hold GNT_ID=%0d required 2", GNT_ID);
    end
    wait_quiet("single");
  endtask

  task automatic test_simultaneous();
    int t[$];
    RST = 1'b0;
    DIN = 4'b1011;
    tick();
    RST = 1'b1;
    sb.push_back(0);
    sb.push_back(1);
    sb.push_back(3);
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (DOUT === 1'b1) t.push_back(c);
    end
    checks++;
    if (t.size() != 3) begin
      errors++;
      $display("FAIL simul_strobes count=%0d required 3", t.size());
    end else begin
      checks++;
      if (t[0] != 4 || t[1] - t[0] != HOLD + 1 || t[2] - t[1] != HOLD + 1) begin
        errors++;
        $display("FAIL simul_spacing first=%0d gaps=%0d,%0d required 4 and gaps 4,4",
                 t[0], t[1] - t[0], t[2] - t[1]);
      end
    end
    checks++;
    if (OVF !== '0) begin
      errors++;
      $display("FAIL simul_ovf OVF=%b required 0000", OVF);
    end
    DIN = '0;
    wait_quiet("simul");
  endtask

  task automatic test_round_robin();
    DIN = 4'b0010;
    sb.push_back(1);
    tick();
    DIN = '0;
    wait_quiet("rr_setup");
    DIN = 4'b0101;
    sb.push_back(2);
    sb.push_back(0);
    tick();
    DIN = '0;
    tick();
    tick();
    checks++;
    if (PEND !== 4'b0101 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rr_pend PEND=%b BUSY=%b required PEND=0101 BUSY=0", PEND, BUSY);
    end
    tick();
    checks++;
    if (GNT_ID !== 2'd2 || PEND !== 4'b0001 || DOUT !== 1'b1) begin
      errors++;
      $display("FAIL rr_first GNT_ID=%0d PEND=%b DOUT=%b required 2 0001 1", GNT_ID, PEND, DOUT);
    end
    wait_quiet("rr");
  endtask

  task automatic test_overflow();
    DIN = 4'b0001;
    sb.push_back(0);
    sb.push_back(1);
    tick();
    DIN = 4'b0010;
    tick();
    DIN = 4'b0000;
    tick();
    DIN = 4'b0010;
    tick();
    DIN = 4'b0000;
    checks++;
    if (GNT !== 4'b0001 || DOUT !== 1'b1) begin
      errors++;
      $display("FAIL ovf_owner GNT=%b DOUT=%b required 0001 1", GNT, DOUT);
    end
    wait_quiet("ovf");
    checks++;
    if (OVF !== 4'b0010) begin
      errors++;
      $display("FAIL ovf_flag OVF=%b required 0010", OVF);
    end
  endtask

  task automatic test_reset_mid_grant();
    DIN = 4'b1000;
    sb.push_back(3);
    tick();
    DIN = '0;
    tick();
    tick();
    tick();
    checks++;
    if (GNT !== 4'b1000 || DOUT !== 1'b1) begin
      errors++;
      $display("FAIL midrst_grant GNT=%b DOUT=%b required 1000 1", GNT, DOUT);
    end
    tick();
    RST = 1'b0;
    tick();
    checks++;
    if (GNT !== '0 || BUSY !== 1'b0 || PEND !== '0 || DOUT !== 1'b0 || OVF !== '0 || GNT_ID !== '0) begin
      errors++;
      $display("FAIL midrst_clear GNT=%b BUSY=%b PEND=%b DOUT=%b OVF=%b ID=%0d required all 0",
               GNT, BUSY, PEND, DOUT, OVF, GNT_ID);
    end
    RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (DOUT !== 1'b0 || BUSY !== 1'b0 || GNT !== '0) begin
        errors++;
        $display("FAIL midrst_after cycle=%0d DOUT=%b BUSY=%b GNT=%b required 0", i, DOUT, BUSY, GNT);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL midrst_sb_left pending=%0d required 0", sb.size());
    end
  endtask

  initial begin
    RST = 1'b0;
    DIN = '0;
    tick();
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_overflow();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
